// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - multi-cycle RV32I sequencer: FETCH/DECODE/EXEC/MEM/WB with memory timeout trap
module multicycle_ctrl #(
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic [6:0]       opcode,
    input  logic             branch_taken,
    input  logic             mem_ready,
    output logic             imem_req,
    output logic             dmem_req,
    output logic             dmem_we,
    output logic             ir_we,
    output logic             pc_we,
    output logic [1:0]       pc_sel,
    output logic [1:0]       alu_src_a,
    output logic             alu_src_b,
    output logic             rf_we,
    output logic [1:0]       wb_sel,
    output logic [2:0]       state,
    output logic             trap,
    output logic [1:0]       trap_cause,
    output logic             retired,
    output logic [CNT_W-1:0] retired_cnt
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_TRAP   = 3'd6
    } state_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [1:0] CAUSE_ILLEGAL = 2'd1;
    localparam logic [1:0] CAUSE_TIMEOUT = 2'd2;

    // Counter is one bit wider than the limit needs so it can saturate above it.
    localparam int WAIT_W = (MEM_TIMEOUT < 2) ? 2 : $clog2(MEM_TIMEOUT + 1) + 1;
    localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MEM_TIMEOUT);

    state_t            state_q, state_d;
    logic [6:0]        op_q, op_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic [1:0]        cause_q, cause_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic do_retire;
    logic mem_wait;
    logic legal;

    always_comb begin
        legal = 1'b0;
        case (opcode)
            OP_R, OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH,
            OP_JAL, OP_JALR, OP_LUI, OP_AUIPC: legal = 1'b1;
            default:                          legal = 1'b0;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        wait_d    = wait_q;
        cause_d   = cause_q;
        cnt_d     = cnt_q;
        imem_req  = 1'b0;
        dmem_req  = 1'b0;
        dmem_we   = 1'b0;
        ir_we     = 1'b0;
        pc_we     = 1'b0;
        pc_sel    = 2'd0;
        alu_src_a = 2'd0;
        alu_src_b = 1'b0;
        rf_we     = 1'b0;
        wb_sel    = 2'd0;
        retired   = 1'b0;
        do_retire = 1'b0;
        mem_wait  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (run) begin
                    state_d = S_FETCH;
                    wait_d  = '0;
                end
            end
            S_FETCH: begin
                imem_req = 1'b1;
                if (mem_ready) begin
                    ir_we   = 1'b1;
                    state_d = S_DECODE;
                end else begin
                    mem_wait = 1'b1;
                end
            end
            S_DECODE: begin
                op_d = opcode;
                if (legal) begin
                    state_d = S_EXEC;
                end else begin
                    state_d = S_TRAP;
                    cause_d = CAUSE_ILLEGAL;
                end
            end
            S_EXEC: begin
                case (op_q)
                    OP_R: begin
                        alu_src_a = 2'd0;
                        alu_src_b = 1'b0;
                    end
                    OP_IMM, OP_LOAD, OP_STORE, OP_JALR: begin
                        alu_src_a = 2'd0;
                        alu_src_b = 1'b1;
                    end
                    OP_LUI: begin
                        alu_src_a = 2'd2;
                        alu_src_b = 1'b1;
                    end
                    OP_AUIPC: begin
                        alu_src_a = 2'd1;
                        alu_src_b = 1'b1;
                    end
                    default: begin
                        alu_src_a = 2'd0;
                        alu_src_b = 1'b0;
                    end
                endcase
                if (op_q == OP_BRANCH) begin
                    pc_we     = 1'b1;
                    pc_sel    = branch_taken ? 2'd1 : 2'd0;
                    do_retire = 1'b1;
                end else if (op_q == OP_LOAD || op_q == OP_STORE) begin
                    state_d = S_MEM;
                    wait_d  = '0;
                end else begin
                    state_d = S_WB;
                end
            end
            S_MEM: begin
                dmem_req = 1'b1;
                dmem_we  = (op_q == OP_STORE);
                if (mem_ready) begin
                    if (op_q == OP_STORE) begin
                        pc_we     = 1'b1;
                        pc_sel    = 2'd0;
                        do_retire = 1'b1;
                    end else begin
                        state_d = S_WB;
                    end
                end else begin
                    mem_wait = 1'b1;
                end
            end
            S_WB: begin
                rf_we     = 1'b1;
                pc_we     = 1'b1;
                do_retire = 1'b1;
                case (op_q)
                    OP_LOAD: wb_sel = 2'd1;
                    OP_JAL:  wb_sel = 2'd2;
                    OP_JALR: wb_sel = 2'd2;
                    default: wb_sel = 2'd0;
                endcase
                case (op_q)
                    OP_JAL:  pc_sel = 2'd1;
                    OP_JALR: pc_sel = 2'd2;
                    default: pc_sel = 2'd0;
                endcase
            end
            S_TRAP: begin
                state_d = S_TRAP;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // A ready arriving on the limit cycle completes the handshake, so only stalled cycles can trap.
        if (mem_wait) begin
            if (MEM_TIMEOUT != 0 && wait_q == WAIT_LIMIT - WAIT_W'(1)) begin
                state_d = S_TRAP;
                cause_d = CAUSE_TIMEOUT;
            end else if (wait_q != '1) begin
                wait_d = wait_q + WAIT_W'(1);
            end
        end

        if (do_retire) begin
            retired = 1'b1;
            cnt_d   = cnt_q + CNT_W'(1);
            state_d = run ? S_FETCH : S_IDLE;
            wait_d  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            op_q    <= '0;
            wait_q  <= '0;
            cause_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            wait_q  <= wait_d;
            cause_q <= cause_d;
            cnt_q   <= cnt_d;
        end
    end

    assign state       = state_q;
    assign trap        = (state_q == S_TRAP);
    assign trap_cause  = cause_q;
    assign retired_cnt = cnt_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb/tb_multicycle_ctrl.sv - directed-vector bench for multicycle_ctrl
module tb_multicycle_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       run;
    logic [6:0] opcode;
    logic       branch_taken;
    logic       mem_ready;
    logic       imem_req, dmem_req, dmem_we, ir_we, pc_we;
    logic [1:0] pc_sel, alu_src_a, wb_sel, trap_cause;
    logic       alu_src_b, rf_we, trap, retired;
    logic [2:0] state;
    logic [2:0] retired_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    always #10 clk = ~clk;

    multicycle_ctrl #(.MEM_TIMEOUT(4), .CNT_W(3)) dut (
        .clk(clk), .rst(rst), .run(run), .opcode(opcode),
        .branch_taken(branch_taken), .mem_ready(mem_ready),
        .imem_req(imem_req), .dmem_req(dmem_req), .dmem_we(dmem_we),
        .ir_we(ir_we), .pc_we(pc_we), .pc_sel(pc_sel),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .rf_we(rf_we),
        .wb_sel(wb_sel), .state(state), .trap(trap), .trap_cause(trap_cause),
        .retired(retired), .retired_cnt(retired_cnt)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; run = 1'b0; opcode = 7'b0; branch_taken = 1'b0; mem_ready = 1'b0;
        step(); step();
        check("rst_state", 32'(state), 0);
        check("rst_trap", 32'(trap), 0);
        check("rst_cause", 32'(trap_cause), 0);
        check("rst_cnt", 32'(retired_cnt), 0);
        check("rst_strobes", {imem_req, dmem_req, pc_we, rf_we, ir_we}, 0);

        // R-type, zero-wait memory
        rst = 1'b0; run = 1'b1; opcode = 7'b0110011; mem_ready = 1'b1;
        step(); #1;
        check("r_fetch", 32'(state), 1);
        check("r_ir_we", {imem_req, ir_we}, 2'b11);
        step(); check("r_decode", 32'(state), 2);
        step(); check("r_exec", 32'(state), 3);
        check("r_alu_src", {alu_src_a, alu_src_b}, 3'b000);
        step(); check("r_wb", 32'(state), 5);
        check("r_wb_ctl", {rf_we, pc_we, wb_sel, pc_sel, retired}, 7'b1100001);
        step();
        check("r_cnt", 32'(retired_cnt), 1);
        check("r_back_fetch", 32'(state), 1);

        // Load: 3 wait cycles in FETCH, 2 in MEM
        opcode = 7'b0000011; mem_ready = 1'b0; #1;
        check("ld_fetch_wait", {imem_req, ir_we}, 2'b10);
        step(); step();
        check("ld_fetch_c3", 32'(state), 1);
        step(); mem_ready = 1'b1; #1;
        check("ld_fetch_ready", 32'(ir_we), 1);
        step(); check("ld_decode", 32'(state), 2);
        step(); check("ld_exec_src", {alu_src_a, alu_src_b}, 3'b001);
        mem_ready = 1'b0;
        step(); #1;
        check("ld_mem", {32'(state), dmem_req, dmem_we}, {32'd4, 2'b10});
        step();
        check("ld_mem_c8_we", 32'(dmem_we), 0);
        step(); mem_ready = 1'b1; #1;
        check("ld_mem_c9", 32'(state), 4);
        step();
        check("ld_wb", {32'(state), rf_we, wb_sel}, {32'd5, 3'b101});
        step();
        check("ld_cnt", 32'(retired_cnt), 2);

        // Branch taken, then not taken
        opcode = 7'b1100011; branch_taken = 1'b1;
        step(); step();
        check("bt_exec", {32'(state), pc_we, pc_sel, rf_we, retired}, {32'd3, 5'b10101});
        step();
        check("bt_fetch", 32'(state), 1);
        branch_taken = 1'b0;
        step(); step();
        check("bn_exec", {pc_we, pc_sel, rf_we, retired}, 5'b10001);
        step();
        check("bn_cnt", 32'(retired_cnt), 4);

        // Store
        opcode = 7'b0100011;
        step(); step(); step();
        check("st_mem", {32'(state), dmem_req, dmem_we, pc_we, pc_sel, retired, rf_we}, {32'd4, 7'b1110010});
        step();
        check("st_cnt", {32'(state), 32'(retired_cnt)}, {32'd1, 32'd5});

        // jalr, run dropped in EXEC
        opcode = 7'b1100111;
        step(); step();
        run = 1'b0; #1;
        check("jalr_exec_src", {alu_src_a, alu_src_b}, 3'b001);
        step();
        check("jalr_wb", {rf_we, wb_sel, pc_sel}, 5'b11010);
        step();
        check("jalr_idle", {32'(state), 32'(retired_cnt)}, {32'd0, 32'd6});

        // Two R-type instructions wrap the 3-bit counter 7 -> 0
        run = 1'b1; opcode = 7'b0110011;
        step();
        repeat (4) step();
        check("wrap_pre", 32'(retired_cnt), 7);
        repeat (4) step();
        check("wrap_zero", 32'(retired_cnt), 0);

        // Illegal opcode traps and holds until reset
        opcode = 7'b0000000;
        step(); step();
        check("ill_trap", {32'(state), trap, trap_cause, imem_req}, {32'd6, 4'b1010});
        repeat (3) step();
        check("ill_hold", {32'(state), trap_cause}, {32'd6, 2'd1});
        rst = 1'b1;
        step();
        check("ill_rst", {32'(state), trap, trap_cause, 3'(retired_cnt)}, {32'd0, 6'b0});

        // Fetch timeout after 4 wait cycles
        rst = 1'b0; opcode = 7'b0110011; mem_ready = 1'b0;
        step(); step(); step(); step();
        check("to_c4_fetch", 32'(state), 1);
        step();
        check("to_trap", {32'(state), trap, trap_cause}, {32'd6, 3'b110});

        // Ready on the limit cycle completes normally
        rst = 1'b1; step();
        rst = 1'b0;
        step(); step(); step(); step();
        mem_ready = 1'b1;
        step();
        check("to_ready_decode", {32'(state), trap}, {32'd2, 1'b0});

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
